// File: rtl/apb_cmd_master.sv
// APB4 initiator: single-beat cmd_* requests become SETUP/ACCESS transfers; optional watchdog via APB_CMD_MASTER_TIMEOUT_EN.
// Latency: psel 1 cycle after accept, penable 2, rsp_valid 3 (plus slave wait states); 3 cycles/transfer minimum.
// Backpressure: cmd_ready only in IDLE; rsp_valid is a one-cycle pulse with no backpressure.
module apb_cmd_master #(
  parameter int ADDR_W         = 12,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_strb,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                psel,
  output logic                penable,
  output logic                pwrite,
  output logic [ADDR_W-1:0]   paddr,
  output logic [DATA_W-1:0]   pwdata,
  output logic [DATA_W/8-1:0] pstrb,
  input  logic [DATA_W-1:0]   prdata,
  input  logic                pready,
  input  logic                pslverr,
  output logic [15:0]         xfer_cnt,
  output logic [15:0]         err_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   accept;
  logic   complete;
  logic   abort;
  logic   done;
  logic   done_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    complete  = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          accept    = 1'b1;
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        state_nxt = ACCESS;
      end
      ACCESS: begin
        // pslverr/prdata are only meaningful on a qualified APB completion
        if (psel && penable && pready) begin
          complete  = 1'b1;
          state_nxt = IDLE;
        end else if (abort) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign cmd_ready = (state == IDLE);
  assign done      = complete || abort;
  assign done_err  = complete ? pslverr : 1'b1;

`ifdef APB_CMD_MASTER_TIMEOUT_EN
  localparam int WAIT_CLOG = $clog2(TIMEOUT_CYCLES + 1);
  localparam int WAIT_W    = (WAIT_CLOG > 8) ? WAIT_CLOG : 8;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  logic [WAIT_W-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (rst || state == SETUP) begin
      wait_cnt <= '0;
    end else if (state == ACCESS && !pready) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Abort on the edge that ends the TIMEOUT_CYCLES-th stalled ACCESS cycle; pready wins a tie.
  assign abort = (state == ACCESS) && !pready && (wait_cnt >= WAIT_LAST);
`else
  // Without the watchdog ACCESS waits on pready forever; TIMEOUT_CYCLES has no effect.
  assign abort = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      pstrb     <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      xfer_cnt  <= '0;
      err_cnt   <= '0;
    end else begin
      rsp_valid <= 1'b0;
      if (accept) begin
        psel   <= 1'b1;
        pwrite <= cmd_write;
        paddr  <= cmd_addr;
        pwdata <= cmd_write ? cmd_wdata : '0;
        pstrb  <= cmd_write ? cmd_strb  : '0;
      end
      if (state == SETUP) begin
        penable <= 1'b1;
      end
      if (done) begin
        psel      <= 1'b0;
        penable   <= 1'b0;
        rsp_valid <= 1'b1;
        rsp_err   <= done_err;
        rsp_rdata <= (complete && !pwrite) ? prdata : '0;
        if (xfer_cnt != 16'hFFFF) begin
          xfer_cnt <= xfer_cnt + 16'd1;
        end
        if (done_err && err_cnt != 16'hFFFF) begin
          err_cnt <= err_cnt + 16'd1;
        end
      end
    end
  end

endmodule
